// File: rtl/meas_lut_pkg.sv
// meas_lut_pkg
//   Shared types and constants for the measurement-outcome lookup engine.
//   - state_t          : engine FSM states (COLLECT -> LOOKUP -> OUTPUT).
//   - N_MEAS_MAX       : largest supported channel count (table depth 2**N_MEAS_MAX).
//   - TIMEOUT_CYCLES_DFLT / to_cnt_w() : collection-timeout defaults and counter
//     width, $clog2(TIMEOUT_CYCLES) with a floor of one bit.
package meas_lut_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    LOOKUP  = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  localparam int N_MEAS_MAX          = 10;
  localparam int TIMEOUT_CYCLES_DFLT = 1024;

  function automatic int to_cnt_w(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/meas_lut_ram.sv
// meas_lut_ram
//   1W1R synchronous RAM, depth 2**ADDR_W x DATA_W, read-before-write: a read
//   and a write of the same address on one edge return the old contents.
//   Contents are not reset.
// Ports:
//   clk      in  clock
//   wr_en    in  write strobe
//   wr_addr  in  ADDR_W  write address
//   wr_data  in  DATA_W  write data
//   rd_en    in  read strobe; rd_data only changes when this is high
//   rd_addr  in  ADDR_W  read address
//   rd_data  out DATA_W  registered read data
module meas_lut_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 5
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/meas_lut_engine.sv
// meas_lut_engine
//   Collects per-channel measurement bits until every channel selected by a
//   writable mask has reported, then looks the masked outcome vector up in a
//   writable table and presents the N_CORES-wide entry with a one-cycle strobe.
//   Optional collection timeout: define MEAS_LUT_TIMEOUT_EN to enable it;
//   without it the timeout port is tied 0 and TIMEOUT_CYCLES is unused.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   meas / meas_valid       N_MEAS outcome bits and their per-channel strobes
//   mask_wr_en/_data        replace the participation mask, restart collection
//   tbl_wr_en/_addr/_data   write one table entry
//   lut_out                 looked-up word, holds between strobes
//   lut_valid               one-cycle strobe, lut_out new this cycle
//   busy                    masked channel accumulated or lookup in flight
//   timeout                 one-cycle strobe, collection abandoned
module meas_lut_engine
  import meas_lut_pkg::*;
#(
  parameter int N_MEAS         = 8,
  parameter int N_CORES        = 5,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DFLT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_MEAS-1:0]  meas,
  input  logic [N_MEAS-1:0]  meas_valid,
  input  logic               mask_wr_en,
  input  logic [N_MEAS-1:0]  mask_wr_data,
  input  logic               tbl_wr_en,
  input  logic [N_MEAS-1:0]  tbl_wr_addr,
  input  logic [N_CORES-1:0] tbl_wr_data,
  output logic [N_CORES-1:0] lut_out,
  output logic               lut_valid,
  output logic               busy,
  output logic               timeout
);

  state_t             state;
  logic [N_MEAS-1:0]  mask;
  logic [N_MEAS-1:0]  acc_v;
  logic [N_MEAS-1:0]  acc_b;
  logic [N_MEAS-1:0]  new_v;
  logic [N_MEAS-1:0]  rd_addr_p1;
  logic [N_CORES-1:0] rd_data_p2;
  logic [N_CORES-1:0] lut_hold;
  logic               complete;
  logic               go;
  logic               expire;

  // Only first reports of masked channels count; acc_b bits stay 0 until
  // their acc_v bit is set, so OR-ing new bits in is safe.
  assign new_v    = meas_valid & mask & ~acc_v;
  assign complete = (state == COLLECT) && (mask != '0) && ((acc_v | new_v) == mask);
  // A mask write or timeout expiry in the same cycle wins over completion.
  assign go       = complete && !mask_wr_en && !expire;

`ifdef MEAS_LUT_TIMEOUT_EN
  localparam int               TO_W    = to_cnt_w(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  function automatic logic [TO_W-1:0] sat_inc(input logic [TO_W-1:0] v);
    return (v == TO_LAST) ? v : v + TO_W'(1);
  endfunction

  logic [TO_W-1:0] to_cnt;

  // The counter holds the number of cycles since the first masked report,
  // so it reads TIMEOUT_CYCLES-1 exactly TIMEOUT_CYCLES-1 cycles later.
  always_ff @(posedge clk) begin
    if (reset || mask_wr_en || go || expire) to_cnt <= '0;
    else if ((acc_v != '0) || (new_v != '0)) to_cnt <= sat_inc(to_cnt);
  end

  assign expire = (state == COLLECT) && (to_cnt == TO_LAST);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign expire = 1'b0;
`endif

  assign timeout = expire;
  assign busy    = (state != COLLECT) || (acc_v != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= COLLECT;
      mask      <= '0;
      acc_v     <= '0;
      acc_b     <= '0;
      lut_valid <= 1'b0;
      lut_hold  <= '0;
    end else begin
      lut_valid <= 1'b0;
      // Accumulation runs in every state so reports arriving during a lookup
      // feed the next round.
      if (mask_wr_en) begin
        mask  <= mask_wr_data;
        acc_v <= '0;
        acc_b <= '0;
      end else if (expire || go) begin
        acc_v <= '0;
        acc_b <= '0;
      end else begin
        acc_v <= acc_v | new_v;
        acc_b <= acc_b | (meas & new_v);
      end
      case (state)
        COLLECT: if (go) state <= LOOKUP;
        LOOKUP: begin
          state     <= OUTPUT;
          lut_valid <= 1'b1;
        end
        OUTPUT: begin
          state    <= COLLECT;
          lut_hold <= rd_data_p2;
        end
        default: state <= COLLECT;
      endcase
    end
  end

  // ---- stage p1: snapshot of the completed outcome vector ----
  always_ff @(posedge clk) begin
    if (go) rd_addr_p1 <= acc_b | (meas & new_v);
  end

  // ---- stage p2: table read during LOOKUP ----
  meas_lut_ram #(
    .ADDR_W (N_MEAS),
    .DATA_W (N_CORES)
  ) u_ram (
    .clk     (clk),
    .wr_en   (tbl_wr_en),
    .wr_addr (tbl_wr_addr),
    .wr_data (tbl_wr_data),
    .rd_en   (state == LOOKUP),
    .rd_addr (rd_addr_p1),
    .rd_data (rd_data_p2)
  );

  // In OUTPUT the fresh read data is shown directly; lut_hold keeps it after.
  assign lut_out = (state == OUTPUT) ? rd_data_p2 : lut_hold;

endmodule

// File: tb/tb_meas_lut_engine.sv
// tb_meas_lut_engine
//   Directed bench for meas_lut_engine (N_MEAS=8, N_CORES=5, TIMEOUT_CYCLES=16).
//   Stimulus pushes expected {lut_out, cycle} entries into a queue; a monitor
//   pops and compares on every lut_valid strobe.
module tb_meas_lut_engine;

  localparam int N_MEAS  = 8;
  localparam int N_CORES = 5;
  localparam int TO_CYC  = 16;

  logic               clk = 1'b0;
  logic               reset;
  logic [N_MEAS-1:0]  meas, meas_valid, mask_wr_data, tbl_wr_addr;
  logic               mask_wr_en, tbl_wr_en;
  logic [N_CORES-1:0] tbl_wr_data, lut_out;
  logic               lut_valid, busy, timeout;

  meas_lut_engine #(
    .N_MEAS         (N_MEAS),
    .N_CORES        (N_CORES),
    .TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .meas         (meas),
    .meas_valid   (meas_valid),
    .mask_wr_en   (mask_wr_en),
    .mask_wr_data (mask_wr_data),
    .tbl_wr_en    (tbl_wr_en),
    .tbl_wr_addr  (tbl_wr_addr),
    .tbl_wr_data  (tbl_wr_data),
    .lut_out      (lut_out),
    .lut_valid    (lut_valid),
    .busy         (busy),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [N_CORES-1:0] data;
    int                 cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_word(input string name, input logic [N_CORES-1:0] act,
                            input logic [N_CORES-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Call in the cycle the last masked report is driven.
  task automatic expect_out(input logic [N_CORES-1:0] d, input int lat);
    exp_t e;
    e.data = d;
    e.cyc  = cyc + lat;
    exp_q.push_back(e);
  endtask

  task automatic pulse_meas(input logic [N_MEAS-1:0] v, input logic [N_MEAS-1:0] m);
    meas_valid = v;
    meas       = m;
    step();
    meas_valid = '0;
    meas       = '0;
  endtask

  task automatic wr_mask(input logic [N_MEAS-1:0] m);
    mask_wr_en   = 1'b1;
    mask_wr_data = m;
    step();
    mask_wr_en   = 1'b0;
  endtask

  task automatic wr_tbl(input logic [N_MEAS-1:0] a, input logic [N_CORES-1:0] d);
    tbl_wr_en   = 1'b1;
    tbl_wr_addr = a;
    tbl_wr_data = d;
    step();
    tbl_wr_en   = 1'b0;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (lut_valid === 1'b1) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_strobe: lut_valid with lut_out=%b at cycle %0d, expected no strobe",
                 lut_out, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (lut_out !== e.data || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL lookup_result: got %b at cycle %0d, expected %b at cycle %0d",
                   lut_out, cyc, e.data, e.cyc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int first_to;
    int to_hits;
    int busy_low;

    reset        = 1'b1;
    meas         = '0;
    meas_valid   = '0;
    mask_wr_en   = 1'b0;
    mask_wr_data = '0;
    tbl_wr_en    = 1'b0;
    tbl_wr_addr  = '0;
    tbl_wr_data  = '0;
    idle(3);
    check_word("reset_lut_out", lut_out, 5'b00000);
    check_bit("reset_lut_valid", lut_valid, 1'b0);
    check_bit("reset_busy", busy, 1'b0);
    check_bit("reset_timeout", timeout, 1'b0);
    reset = 1'b0;

    wr_tbl(8'd2, 5'b10000);
    wr_tbl(8'd1, 5'b00100);
    wr_tbl(8'd3, 5'b01010);
    wr_tbl(8'd0, 5'b00011);
    wr_mask(8'h03);

    // 1: ch1=1 first, ch0=0 three cycles later -> addr 2
    pulse_meas(8'h02, 8'h02);
    check_bit("t1_busy_partial", busy, 1'b1);
    idle(2);
    expect_out(5'b10000, 2);
    pulse_meas(8'h01, 8'h00);
    idle(4);
    check_word("t1_hold", lut_out, 5'b10000);
    check_bit("t1_busy_idle", busy, 1'b0);

    // 2: both channels in one cycle -> addr 1, output holds afterwards
    expect_out(5'b00100, 2);
    pulse_meas(8'h03, 8'h01);
    idle(5);
    check_word("t2_hold", lut_out, 5'b00100);
    check_bit("t2_valid_low", lut_valid, 1'b0);

    // 3: duplicate ch0 report ignored, first wins -> addr 1
    pulse_meas(8'h01, 8'h01);
    pulse_meas(8'h01, 8'h00);
    expect_out(5'b00100, 2);
    pulse_meas(8'h02, 8'h00);
    idle(4);

    // 4: full set arrives during OUTPUT -> next round, three cycles later
    expect_out(5'b01010, 2);
    pulse_meas(8'h03, 8'h03);
    step();
    check_bit("t4_in_output", lut_valid, 1'b1);
    expect_out(5'b00011, 3);
    pulse_meas(8'h03, 8'h00);
    idle(5);

    // Table write during LOOKUP of the same address reads the old entry
    expect_out(5'b10000, 2);
    pulse_meas(8'h03, 8'h02);
    wr_tbl(8'd2, 5'b11111);
    idle(4);
    expect_out(5'b11111, 2);
    pulse_meas(8'h03, 8'h02);
    idle(4);

    // Unmasked ch1 contributes nothing to the address
    wr_mask(8'h01);
    expect_out(5'b00100, 2);
    pulse_meas(8'h03, 8'h03);
    idle(4);

    // mask == 0 never completes, busy stays low
    wr_mask(8'h00);
    pulse_meas(8'h03, 8'h03);
    check_bit("mask0_busy", busy, 1'b0);
    idle(4);
    check_bit("mask0_busy_later", busy, 1'b0);

    // 5: mask write after a partial collection restarts it
    wr_mask(8'h03);
    pulse_meas(8'h01, 8'h01);
    check_bit("t5_busy_partial", busy, 1'b1);
    wr_mask(8'h03);
    check_bit("t5_busy_dropped", busy, 1'b0);
    idle(3);
    expect_out(5'b11111, 2);
    pulse_meas(8'h03, 8'h02);
    idle(4);

    // Reset during LOOKUP aborts the lookup with no strobe
    pulse_meas(8'h03, 8'h03);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_word("abort_lut_out", lut_out, 5'b00000);
    check_bit("abort_busy", busy, 1'b0);
    idle(4);
    check_word("abort_lut_out_later", lut_out, 5'b00000);

    // 6: only ch0 reports
    wr_mask(8'h03);
    t0 = cyc;
    pulse_meas(8'h01, 8'h01);
    first_to = -1;
    to_hits  = 0;
    busy_low = 0;
    for (int i = 0; i < 40; i++) begin
      if (timeout === 1'b1) begin
        to_hits++;
        if (first_to < 0) first_to = cyc;
      end
      if (busy !== 1'b1) busy_low++;
      step();
    end
`ifdef MEAS_LUT_TIMEOUT_EN
    check_int("t6_timeout_cycle", first_to, t0 + TO_CYC - 1);
    check_int("t6_timeout_width", to_hits, 1);
    check_bit("t6_busy_after", busy, 1'b0);
`else
    check_int("t6_no_timeout", to_hits, 0);
    check_int("t6_busy_held", busy_low, 0);
    wr_mask(8'h00);
`endif

    idle(5);
    check_int("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
